mem_store_unit: RTL and testbench
=================================

// Module: mem_store_unit
// PURPOSE
// - Store path from register file to byte-wide data memory; reverse of the load path (mdr16/mdr8 -> regfile).
// - Latches a register value (typically reg2val) plus address and size, then emits one (8-bit) or two (16-bit) byte writes.
// - Each byte write uses a we/ack handshake; completion is signalled by a one-cycle st_done pulse.
// - Byte order is little-endian: low byte at addr, high byte at addr+1.
// PARAMETERS
// - ADDR_W       16  memory address width
// - ACK_TIMEOUT  15  max cycles a byte write waits for mem_ack before abort (>=1)
// PORTS
// - clock      in   1       system clock, rising edge
// - reset      in   1       asynchronous, active-high reset
// - st_req     in   1       store request; sampled only in IDLE
// - st_addr    in   ADDR_W  target byte address
// - st_data    in   16      store data (register value)
// - d8_d16     in   1       1 = 8-bit store (st_data[7:0]), 0 = 16-bit store
// - st_busy    out  1       unit occupied; new requests ignored while high
// - st_done    out  1       one-cycle pulse at end of store
// - st_err     out  1       valid with st_done; 1 = timeout or misalign abort
// - mem_we     out  1       byte write strobe, held until acked
// - mem_addr   out  ADDR_W  byte write address
// - mem_wdata  out  8       byte write data
// - mem_ack    in   1       memory accepted current byte; sampled only while mem_we=1
// BEHAVIOUR
// - Single clock. Reset is asynchronous and active-high.
// - All state and outputs are registered.
// - Reset values: state=IDLE; mem_we, mem_addr, mem_wdata, st_busy, st_done and st_err all 0.
// - Reset mid-operation aborts at once: mem_we drops asynchronously, no st_done is issued, and latched data is discarded.
// - FSM states: IDLE, WR_LO, WR_HI, DONE.
// - IDLE: st_busy=0, mem_we=0.
//   - If st_req=1: latch st_addr, st_data and d8_d16; enter WR_LO.
// - WR_LO: mem_we=1, mem_addr=addr_q, mem_wdata=data_q[7:0].
//   - On mem_ack=1, if 8-bit: enter DONE.
//   - On mem_ack=1, if 16-bit: enter WR_HI.
// - WR_HI: mem_we=1, mem_addr=addr_q+1 modulo 2^ADDR_W (0xFFFF wraps to 0x0000), mem_wdata=data_q[15:8].
//   - On mem_ack=1: enter DONE.
// - DONE: st_done=1 and st_err set as applicable for exactly one cycle, then IDLE.
//   - st_err is 0 on the cycle after DONE.
// - st_busy=1 in WR_LO, WR_HI and DONE; a st_req asserted then is dropped, not queued.
// - Wait counter:
//   - Cleared on entry to WR_LO and to WR_HI; increments each cycle without ack.
//   - When it reaches ACK_TIMEOUT with no ack: go to DONE with st_err=1.
//   - A pending high byte is not written after a low-byte timeout.
//   - An ack in the same cycle the counter hits ACK_TIMEOUT counts as success.
// - Latency with zero-wait memory (ack in the first mem_we cycle):
//   - 8-bit: req at cycle 0, mem_we at cycle 1, st_done at cycle 2.
//   - 16-bit: st_done at cycle 3.
// - Back-to-back: st_req may be issued in the first IDLE cycle after DONE.
// - mem_addr and mem_wdata hold their last value when mem_we=0.
// CONFIGURATION
// - Macro STORE_MISALIGN_TRAP_EN.
//   - Defined: a 16-bit store to an odd address does no memory write, goes IDLE -> DONE with st_err=1 (st_done 2 cycles after req).
//   - Undefined: odd 16-bit stores proceed normally (addr, addr+1, wrapping at top).
// TESTING
// - Reset: assert reset mid-WR_HI -> mem_we=0 immediately; all outputs 0; next store proceeds normally.
// - 8-bit store: addr=0x0010, data=0xABCD, ack immediate -> one write (0x0010, 0xCD); st_done at cycle 2, st_err=0.
// - 16-bit store, 3-cycle ack delay per byte: addr=0x0020, data=0x1234 -> (0x0020, 0x34) then (0x0021, 0x12); single st_done.
// - Wrap: 16-bit store, addr=0xFFFF, data=0xBEEF, macro undefined -> (0xFFFF, 0xEF), (0x0000, 0xBE).
//   - With the macro defined: no mem_we, st_done with st_err=1.
// - Timeout: 16-bit store, mem_ack held 0 -> mem_we for ACK_TIMEOUT cycles, then st_done+st_err=1, no WR_HI.
// - Busy drop: second st_req during WR_LO -> ignored; exactly one store observed on memory.

Source files
------------

// File: rtl/mem_store_unit.sv
// Byte-wide store unit: writes one (8-bit) or two (16-bit, little-endian) bytes via a we/ack handshake.
// Optional feature macro STORE_MISALIGN_TRAP_EN: abort odd-address 16-bit stores with st_err instead of writing.
module mem_store_unit #(
  parameter int ADDR_W      = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              st_req,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [15:0]       st_data,
  input  logic              d8_d16,
  output logic              st_busy,
  output logic              st_done,
  output logic              st_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;

  localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              byte_q;
  logic [CNT_W-1:0]  wait_cnt;
`ifdef STORE_MISALIGN_TRAP_EN
  logic              trap_q;
`endif

  // A trapped store parks one cycle in WR_LO with mem_we low so st_done still lands two cycles after the request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      byte_q    <= 1'b0;
      wait_cnt  <= '0;
      st_busy   <= 1'b0;
      st_done   <= 1'b0;
      st_err    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef STORE_MISALIGN_TRAP_EN
      trap_q    <= 1'b0;
`endif
    end else begin
      st_done <= 1'b0;
      st_err  <= 1'b0;
      case (state)
        IDLE: begin
          st_busy <= 1'b0;
          mem_we  <= 1'b0;
          if (st_req) begin
            addr_q   <= st_addr;
            data_q   <= st_data;
            byte_q   <= d8_d16;
            wait_cnt <= '0;
            st_busy  <= 1'b1;
            state    <= WR_LO;
`ifdef STORE_MISALIGN_TRAP_EN
            if (!d8_d16 && st_addr[0]) begin
              trap_q <= 1'b1;
            end else begin
              trap_q    <= 1'b0;
              mem_we    <= 1'b1;
              mem_addr  <= st_addr;
              mem_wdata <= st_data[7:0];
            end
`else
            mem_we    <= 1'b1;
            mem_addr  <= st_addr;
            mem_wdata <= st_data[7:0];
`endif
          end
        end
        WR_LO: begin
`ifdef STORE_MISALIGN_TRAP_EN
          if (trap_q) begin
            state   <= DONE;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
            trap_q  <= 1'b0;
          end else
`endif
          if (mem_ack) begin
            if (byte_q) begin
              state   <= DONE;
              mem_we  <= 1'b0;
              st_done <= 1'b1;
            end else begin
              state     <= WR_HI;
              mem_addr  <= addr_q + 1'b1;
              mem_wdata <= data_q[15:8];
              wait_cnt  <= '0;
            end
          end else if (wait_cnt == CNT_LAST) begin
            state   <= DONE;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WR_HI: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state   <= DONE;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
            st_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state   <= IDLE;
          st_busy <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          st_busy <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_store_unit.sv
// Scoreboard bench for mem_store_unit: directed stores against a memory model with programmable ack delay.
// Expected byte writes and completions are queued at issue time and checked by a negedge monitor.
module tb_mem_store_unit;

  typedef struct {
    logic err;
    int   cyc;
  } done_t;

  logic        clock;
  logic        reset;
  logic        st_req;
  logic [15:0] st_addr;
  logic [15:0] st_data;
  logic        d8_d16;
  logic        st_busy;
  logic        st_done;
  logic        st_err;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;

  int          checks;
  int          errors;
  int          cyc;
  int          ack_delay;
  int          wcnt;
  int          we_cycles;
  logic        prev_done;
  logic [23:0] exp_wr[$];
  done_t       exp_done[$];

  mem_store_unit #(.ADDR_W(16), .ACK_TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .st_req(st_req), .st_addr(st_addr),
    .st_data(st_data), .d8_d16(d8_d16), .st_busy(st_busy), .st_done(st_done),
    .st_err(st_err), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory model and monitor share one process so ack generation and checking see the same sample.
  always @(negedge clock) begin
    if (reset) begin
      wcnt      = 0;
      mem_ack   = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) checkOutput("err_after_done", {31'b0, st_err}, 32'd0);
      prev_done = st_done;
      if (st_done) begin
        if (exp_done.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got st_done=1 err=%0b expected none (cycle %0d)", st_err, cyc);
        end else begin
          done_t d;
          d = exp_done.pop_front();
          checkOutput("done_err", {31'b0, st_err}, {31'b0, d.err});
          checkOutput("done_cycle", cyc, d.cyc);
        end
      end
      if (!mem_we) begin
        wcnt    = 0;
        mem_ack = 1'b0;
      end else begin
        we_cycles++;
        if (ack_delay >= 0 && wcnt == ack_delay) begin
          mem_ack = 1'b1;
          wcnt    = 0;
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_write: got addr=0x%04h data=0x%02h expected none", mem_addr, mem_wdata);
          end else begin
            checkOutput("write_addr_data", {8'b0, mem_addr, mem_wdata}, {8'b0, exp_wr.pop_front()});
          end
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Issues one store; hold keeps st_req high for extra cycles while the unit is busy.
  task automatic applyStimulus(input logic [15:0] addr, input logic [15:0] data, input logic d8,
                               input int delay, input int hold, input int lat, input logic err,
                               input int we_exp);
    done_t d;
    #1;
    ack_delay = delay;
    we_cycles = 0;
    d.err     = err;
    d.cyc     = cyc + lat;
    exp_done.push_back(d);
    st_addr = addr;
    st_data = data;
    d8_d16  = d8;
    st_req  = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clock);
      #1;
      checkOutput("busy_during_store", {31'b0, st_busy}, 32'd1);
      st_addr = addr ^ 16'h0F00;
      st_data = ~data;
    end
    @(posedge clock);
    #1;
    st_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_done.size() == 0) break;
      @(posedge clock);
    end
    if (exp_done.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got no st_done expected one within 100 cycles");
      exp_done.delete();
    end
    checkOutput("we_cycles", we_cycles, we_exp);
    checkOutput("pending_writes", exp_wr.size(), 32'd0);
    exp_wr.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    ack_delay = 0;
    we_cycles = 0;
    st_req    = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    d8_d16    = 1'b0;
    mem_ack   = 1'b0;
    reset     = 1'b1;
    #12;
    checkOutput("reset_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset_st_busy", {31'b0, st_busy}, 32'd0);
    checkOutput("reset_st_done", {31'b0, st_done}, 32'd0);
    checkOutput("reset_st_err", {31'b0, st_err}, 32'd0);
    checkOutput("reset_mem_addr", {16'b0, mem_addr}, 32'd0);
    checkOutput("reset_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);

    exp_wr.push_back({16'h0010, 8'hCD});
    applyStimulus(16'h0010, 16'hABCD, 1'b1, 0, 0, 2, 1'b0, 1);

    exp_wr.push_back({16'h0020, 8'h34});
    exp_wr.push_back({16'h0021, 8'h12});
    applyStimulus(16'h0020, 16'h1234, 1'b0, 3, 0, 9, 1'b0, 8);

    exp_wr.push_back({16'h0040, 8'hA5});
    exp_wr.push_back({16'h0041, 8'hC3});
    applyStimulus(16'h0040, 16'hC3A5, 1'b0, 0, 0, 3, 1'b0, 2);

`ifdef STORE_MISALIGN_TRAP_EN
    applyStimulus(16'hFFFF, 16'hBEEF, 1'b0, 0, 0, 2, 1'b1, 0);
    applyStimulus(16'h0101, 16'h7788, 1'b0, 1, 0, 2, 1'b1, 0);
`else
    exp_wr.push_back({16'hFFFF, 8'hEF});
    exp_wr.push_back({16'h0000, 8'hBE});
    applyStimulus(16'hFFFF, 16'hBEEF, 1'b0, 0, 0, 3, 1'b0, 2);
    exp_wr.push_back({16'h0101, 8'h88});
    exp_wr.push_back({16'h0102, 8'h77});
    applyStimulus(16'h0101, 16'h7788, 1'b0, 1, 0, 5, 1'b0, 4);
`endif

    applyStimulus(16'h0200, 16'h1111, 1'b0, -1, 0, 16, 1'b1, 15);

    exp_wr.push_back({16'h0300, 8'h42});
    applyStimulus(16'h0300, 16'h0042, 1'b1, 14, 0, 16, 1'b0, 15);

    exp_wr.push_back({16'h0400, 8'h99});
    applyStimulus(16'h0400, 16'h0099, 1'b1, 2, 1, 4, 1'b0, 3);

    // Reset in the middle of the high-byte write: low byte lands, no completion follows.
    #1;
    ack_delay = 3;
    exp_wr.push_back({16'h0600, 8'h56});
    st_addr = 16'h0600;
    st_data = 16'h3456;
    d8_d16  = 1'b0;
    st_req  = 1'b1;
    @(posedge clock);
    #1;
    st_req = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    checkOutput("midop_hi_addr", {16'b0, mem_addr}, 32'h0601);
    checkOutput("midop_mem_we", {31'b0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("abort_mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("abort_st_busy", {31'b0, st_busy}, 32'd0);
    checkOutput("abort_st_done", {31'b0, st_done}, 32'd0);
    checkOutput("abort_st_err", {31'b0, st_err}, 32'd0);
    checkOutput("abort_mem_addr", {16'b0, mem_addr}, 32'd0);
    checkOutput("abort_mem_wdata", {24'b0, mem_wdata}, 32'd0);
    checkOutput("abort_pending_writes", exp_wr.size(), 32'd0);
    exp_wr.delete();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);

    exp_wr.push_back({16'h0500, 8'h34});
    applyStimulus(16'h0500, 16'h1234, 1'b1, 0, 0, 2, 1'b0, 1);

    repeat (3) @(posedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
